// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   Parametrised UART receiver with configurable data width, optional odd/even
//   parity and one or two stop bits. Completed frames land in a one-entry
//   valid/ready buffer together with per-frame parity and framing error flags.
//   A frame that completes while the buffer is still full is dropped and
//   reported with a single-cycle overrun pulse.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit period (>= 4)
//   DATA_BITS     data bits per frame, 5..9, LSB first
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   i_rx          raw serial line, idle high, asynchronous to clk
//   o_data        received data word, bit 0 = first bit received
//   o_valid       o_data and error flags hold a frame
//   i_ready       consumer accepts the frame when o_valid && i_ready
//   o_parity_err  parity mismatch for the held frame (always 0 when PARITY = 0)
//   o_frame_err   a stop bit of the held frame was sampled low
//   o_overrun     one-cycle pulse: a completed frame was dropped, buffer full
//   o_busy        receiver is in any state other than idle

module uart_rx_framed #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  // Folding the odd/even choice into one bit lets the parity check be a single XOR.
  localparam logic            ParOdd   = (PARITY == 1);
  localparam logic            HasPar   = (PARITY != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StWaitHigh
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Preset to 1 so reset looks like an idle line.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_q      <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q,   state_d;
  logic [CntW-1:0]        cnt_q,     cnt_d;
  logic [BitW-1:0]        bit_q,     bit_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   commit_q,  commit_d;

  logic cnt_at_last;
  assign cnt_at_last = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    commit_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_q) begin
          state_d = StStart;
        end
      end

      // Re-check the line at the middle of the start bit; a high level there
      // means the falling edge was a glitch and the frame is silently dropped.
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_q) begin
            state_d   = StData;
            bit_d     = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // Counter is aligned to the bit centre, so a full period lands on the
      // next centre. Bits shift in from the top so the first lands in bit 0.
      StData: begin
        if (cnt_at_last) begin
          cnt_d   = '0;
          shift_d = {rx_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = HasPar ? StPar : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StPar: begin
        if (cnt_at_last) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_q ^ ParOdd;
          bit_d     = '0;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // A low final stop bit means the line may still be in a break; wait for
      // it to go high before hunting for the next start edge.
      StStop: begin
        if (cnt_at_last) begin
          cnt_d = '0;
          if (!rx_q) begin
            frm_err_d = 1'b1;
          end
          if (bit_q == StopLast) begin
            bit_d    = '0;
            commit_d = 1'b1;
            state_d  = rx_q ? StIdle : StWaitHigh;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitHigh: begin
        cnt_d = '0;
        if (rx_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      commit_q  <= commit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output buffer. commit_q is registered so the buffer sees the
  // flags including the final stop-bit sample.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 perr_o_q,  perr_o_d;
  logic                 ferr_o_q,  ferr_o_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_o_d  = perr_o_q;
    ferr_o_d  = ferr_o_q;
    overrun_d = 1'b0;

    if (commit_q) begin
      // A consume on the same edge frees the slot for the new frame.
      if (!valid_q || i_ready) begin
        data_d   = shift_q;
        perr_o_d = par_err_q;
        ferr_o_d = frm_err_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_o_q  <= 1'b0;
      ferr_o_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_o_q  <= perr_o_d;
      ferr_o_q  <= ferr_o_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_o_q;
  assign o_frame_err  = ferr_o_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Testbench for uart_rx_framed. Three receivers share clock and reset:
//   a: 8N1, b: 7 data bits with even parity, c: 8 data bits, 2 stop bits.
// Expected frames come from a word-level model of the serial format.

module tb_uart_rx_framed;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_a, ready_a, valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic       rx_b, ready_b, valid_b, perr_b, ferr_b, ovr_b, busy_b;
  logic [6:0] data_b;
  logic       rx_c, ready_c, valid_c, perr_c, ferr_c, ovr_c, busy_c;
  logic [7:0] data_c;

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .i_rx(rx_a), .o_data(data_a), .o_valid(valid_a), .i_ready(ready_a),
    .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overrun(ovr_a), .o_busy(busy_a)
  );

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .i_rx(rx_b), .o_data(data_b), .o_valid(valid_b), .i_ready(ready_b),
    .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_overrun(ovr_b), .o_busy(busy_b)
  );

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .i_rx(rx_c), .o_data(data_c), .o_valid(valid_c), .i_ready(ready_c),
    .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_overrun(ovr_c), .o_busy(busy_c)
  );

  int errors = 0;
  int checks = 0;

  // Accepted frames, packed as {frame_err, parity_err, data[8:0]}.
  logic [10:0] got_a[$];
  logic [10:0] got_b[$];
  logic [10:0] got_c[$];
  int          ovr_cnt_a = 0;

  // Inputs change 1 time unit after posedge, so negedge sees the values the
  // next posedge will act on.
  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back({ferr_a, perr_a, 1'b0, data_a});
    if (valid_b && ready_b) got_b.push_back({ferr_b, perr_b, 2'b00, data_b});
    if (valid_c && ready_c) got_c.push_back({ferr_c, perr_c, 1'b0, data_c});
    if (ovr_a) ovr_cnt_a++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level frame model: what the receiver must report for a frame.
  function automatic logic [10:0] model(input logic [8:0] d, input int nbits, input int par,
                                        input bit pbit, input int nstop, input logic [1:0] stopv);
    logic [8:0] m;
    int         ones;
    bit         perr;
    bit         ferr;
    m    = d & 9'((1 << nbits) - 1);
    ones = $countones(m) + int'(pbit);
    perr = (par == 0) ? 1'b0 : ((ones % 2) != ((par == 1) ? 1 : 0));
    ferr = (stopv[0] == 1'b0) || (nstop == 2 && stopv[1] == 1'b0);
    return {ferr, perr, m};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int inst, input logic v);
    set_rx(inst, v);
    wait_clks(CPB);
  endtask

  task automatic send_bits(input int inst, input logic [8:0] d, input int nbits);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(inst, d[i]);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                            input bit has_par, input bit pbit, input int nstop,
                            input logic [1:0] stopv);
    send_bits(inst, d, nbits);
    if (has_par) drive_bit(inst, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(inst, stopv[i]);
    set_rx(inst, 1'b1);
    wait_clks(6);
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return got_a.size();
      1:       return got_b.size();
      default: return got_c.size();
    endcase
  endfunction

  task automatic expect_frame(input int inst, input string tag, input logic [10:0] exp,
                              output logic [10:0] got);
    got = '0;
    for (int i = 0; i < 64 && qsize(inst) == 0; i++) wait_clks(1);
    chk({tag, "_arrived"}, 32'(qsize(inst) > 0), 1);
    if (qsize(inst) > 0) begin
      case (inst)
        0:       got = got_a.pop_front();
        1:       got = got_b.pop_front();
        default: got = got_c.pop_front();
      endcase
      chk(tag, got, exp);
    end
  endtask

  initial begin
    logic [10:0] w;
    logic [8:0]  d;
    bit          pb;
    int          ovr_base;
    logic [1:0]  sv;

    rst = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    wait_clks(3);

    // Reset state
    chk("rst_data", data_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_perr", perr_a, 0);
    chk("rst_ferr", ferr_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid_bc", {valid_b, valid_c, busy_b, busy_c}, 0);
    rst = 1'b0;
    wait_clks(4);

    // 8N1 0xA5
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
    expect_frame(0, "t1_a5", model(9'h0A5, 8, 0, 1'b0, 1, 2'b11), w);
    chk("t1_data", w[8:0], 9'h0A5);
    chk("t1_one_frame", got_a.size(), 0);
    chk("t1_no_overrun", ovr_cnt_a, 0);

    // Even parity, 7 bits: good then bad parity bit
    send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1, 2'b11);
    expect_frame(1, "t2_good", model(9'h055, 7, 2, 1'b0, 1, 2'b11), w);
    chk("t2_good_perr", w[9], 0);
    send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1, 2'b11);
    expect_frame(1, "t2_bad", model(9'h055, 7, 2, 1'b1, 1, 2'b11), w);
    chk("t2_bad_perr", w[9], 1);
    chk("t2_bad_data", w[6:0], 7'h55);

    // Two stop bits, second low, line held low afterwards
    d = 9'($urandom_range(0, 255));
    send_bits(2, d, 8);
    drive_bit(2, 1'b1);
    set_rx(2, 1'b0);
    wait_clks(CPB);
    wait_clks(CPB * 3 / 2);
    chk("t3_busy_while_low", busy_c, 1);
    chk("t3_one_frame_while_low", got_c.size(), 1);
    wait_clks(CPB * 3 / 2);
    set_rx(2, 1'b1);
    wait_clks(CPB * 2);
    expect_frame(2, "t3_ferr", model(d, 8, 0, 1'b0, 2, 2'b01), w);
    chk("t3_ferr_bit", w[10], 1);
    chk("t3_no_spurious", got_c.size(), 0);
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 2'b11);
    expect_frame(2, "t3_3c", model(9'h03C, 8, 0, 1'b0, 2, 2'b11), w);

    // Backpressure and overrun
    ready_a  = 1'b0;
    ovr_base = ovr_cnt_a;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11);
    chk("t4_valid_first", valid_a, 1);
    chk("t4_data_first", data_a, 8'h11);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11);
    chk("t4_overrun_pulses", ovr_cnt_a - ovr_base, 1);
    chk("t4_data_held", data_a, 8'h11);
    chk("t4_valid_held", valid_a, 1);
    chk("t4_overrun_low_after", ovr_a, 0);
    ready_a = 1'b1;
    expect_frame(0, "t4_consume", model(9'h011, 8, 0, 1'b0, 1, 2'b11), w);
    wait_clks(2);
    chk("t4_valid_cleared", valid_a, 0);
    chk("t4_second_dropped", got_a.size(), 0);

    // Start glitch of 5 clocks
    set_rx(0, 1'b0);
    wait_clks(5);
    set_rx(0, 1'b1);
    wait_clks(2);
    chk("t5_busy_in_start", busy_a, 1);
    wait_clks(20);
    chk("t5_back_idle", busy_a, 0);
    chk("t5_no_valid", valid_a, 0);
    chk("t5_no_frame", got_a.size(), 0);
    send_frame(0, 9'h080, 8, 1'b0, 1'b0, 1, 2'b11);
    expect_frame(0, "t5_80", model(9'h080, 8, 0, 1'b0, 1, 2'b11), w);

    // Reset during the fourth data bit of 0xFF
    fork
      send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 2'b11);
      begin
        wait_clks(CPB * 4 + 8);
        chk("t6_busy_before_rst", busy_a, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_data", data_a, 0);
        chk("t6_rst_valid", valid_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_flags", {perr_a, ferr_a, ovr_a}, 0);
        wait_clks(3);
        rst = 1'b0;
      end
    join
    wait_clks(CPB);
    chk("t6_no_partial", got_a.size(), 0);
    chk("t6_idle", busy_a, 0);
    send_frame(0, 9'h001, 8, 1'b0, 1'b0, 1, 2'b11);
    expect_frame(0, "t6_01", model(9'h001, 8, 0, 1'b0, 1, 2'b11), w);

    // Random traffic against the model
    for (int i = 0; i < 8; i++) begin
      d = 9'($urandom_range(0, 255));
      send_frame(0, d, 8, 1'b0, 1'b0, 1, 2'b11);
      expect_frame(0, "rnd_a", model(d, 8, 0, 1'b0, 1, 2'b11), w);
    end
    for (int i = 0; i < 6; i++) begin
      d  = 9'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      send_frame(1, d, 7, 1'b1, pb, 1, 2'b11);
      expect_frame(1, "rnd_b", model(d, 7, 2, pb, 1, 2'b11), w);
    end
    for (int i = 0; i < 3; i++) begin
      d  = 9'($urandom_range(0, 255));
      sv = {1'b1, 1'($urandom_range(0, 1))};
      send_frame(2, d, 8, 1'b0, 1'b0, 2, sv);
      expect_frame(2, "rnd_c", model(d, 8, 0, 1'b0, 2, sv), w);
    end
    chk("end_no_overrun", ovr_cnt_a - ovr_base, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
